// File: rtl/alu_result_display.sv
// Four-digit, common-anode seven-segment scanner for the shift/arithmetic test unit.
// It takes a snapshot of the unit's results once per scan and shows one of three pages, selected by a debounced button.
module alu_result_display #(
  parameter int unsigned REFRESH_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] logical_shift,
  input  logic [3:0] arithmetic_shift,
  input  logic [7:0] combined,
  input  logic [3:0] sum,
  input  logic       carry_out,
  input  logic [7:0] product,
  input  logic       page_btn,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic [1:0] page,
  output logic       led_carry
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]       BLANK    = 5'h10;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] logical_shift;
    logic [3:0] arithmetic_shift;
    logic [7:0] combined;
    logic [3:0] sum;
    logic       carry_out;
    logic [7:0] product;
  } snap_t;

  // Hex digit to active-low segments; bit 4 of the code requests a blank digit.
  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    logic [6:0] s;
    case (code[3:0])
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return code[4] ? 7'b1111111 : s;
  endfunction

  // Page map; an out-of-range page falls back to page 0's layout.
  function automatic logic [4:0] digit_sel(input snap_t s, input logic [1:0] pg,
                                           input logic [1:0] idx);
    logic [4:0] d;
    case (pg)
      2'd1: begin
        case (idx)
          2'd0:    d = {1'b0, s.arithmetic_shift};
          2'd1:    d = {1'b0, s.logical_shift};
          2'd2:    d = {1'b0, s.sum};
          default: d = {2'b00, 2'b00, s.carry_out};
        endcase
      end
      2'd2: begin
        case (idx)
          2'd0:    d = {1'b0, s.combined[3:0]};
          2'd1:    d = {1'b0, s.combined[7:4]};
          default: d = BLANK;
        endcase
      end
      default: begin
        case (idx)
          2'd0:    d = {1'b0, s.product[3:0]};
          2'd1:    d = {1'b0, s.product[7:4]};
          2'd2:    d = {1'b0, s.b};
          default: d = {1'b0, s.a};
        endcase
      end
    endcase
    return d;
  endfunction

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  snap_t            snap_q, snap_d;
  logic [6:0]       seg_n_q, seg_n_d;
  logic [3:0]       an_n_q, an_n_d;
  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_prev_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]       page_q, page_d;
  logic             tick_c;

  // Scan, snapshot, debounce and page next-state logic.
  always_comb begin
    pre_d     = pre_q + PRE_W'(1);
    idx_d     = idx_q;
    snap_d    = snap_q;
    seg_n_d   = seg_n_q;
    an_n_d    = an_n_q;
    stable_d  = stable_q;
    deb_cnt_d = '0;
    page_d    = page_q;
    tick_c    = (pre_q == PRE_LAST);

    if (tick_c) begin
      pre_d   = '0;
      an_n_d  = ~(4'b0001 << idx_q);
      seg_n_d = seg_decode(digit_sel(snap_q, page_q, idx_q));
      idx_d   = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_d = '{a: a, b: b, logical_shift: logical_shift,
                   arithmetic_shift: arithmetic_shift, combined: combined,
                   sum: sum, carry_out: carry_out, product: product};
      end
    end

    if (sync2_q != stable_q) begin
      if (deb_cnt_q == DEB_LAST) stable_d = ~stable_q;
      else                       deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end

    // Advance one cycle after the debounced level rises.
    if (stable_q && !stable_prev_q) begin
      case (page_q)
        2'd0:    page_d = 2'd1;
        2'd1:    page_d = 2'd2;
        2'd2:    page_d = 2'd0;
        default: page_d = 2'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q         <= '0;
      idx_q         <= '0;
      snap_q        <= '0;
      seg_n_q       <= 7'h7F;
      an_n_q        <= 4'hF;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      deb_cnt_q     <= '0;
      page_q        <= '0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      seg_n_q       <= seg_n_d;
      an_n_q        <= an_n_d;
      sync1_q       <= page_btn;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      deb_cnt_q     <= deb_cnt_d;
      page_q        <= page_d;
    end
  end

  assign seg_n     = seg_n_q;
  assign an_n      = an_n_q;
  assign page      = page_q;
  assign led_carry = snap_q.carry_out;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with a short refresh period and a short debounce window.
module tb_alu_result_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = 4'h3, b = 4'h5, logical_shift = 4'h0, arithmetic_shift = 4'h0;
  logic [7:0] combined = 8'h00, product = 8'h0F;
  logic [3:0] sum = 4'h0;
  logic       carry_out = 1'b0;
  logic       page_btn = 1'b0;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic [1:0] page;
  logic       led_carry;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_display #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .logical_shift(logical_shift),
    .arithmetic_shift(arithmetic_shift), .combined(combined), .sum(sum),
    .carry_out(carry_out), .product(product), .page_btn(page_btn),
    .seg_n(seg_n), .an_n(an_n), .page(page), .led_carry(led_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_wait();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    check({tag, "_an"}, 32'(an_n), 32'(an_exp));
    check({tag, "_seg"}, 32'(seg_n), 32'(seg_exp));
  endtask

  // Land just after the next tick that displays digit 3 (the snapshot tick).
  task automatic align_digit3();
    int k;
    k = 0;
    #1;
    while (an_n == 4'h7 && k < 40) begin @(posedge clk); #1; k++; end
    while (an_n != 4'h7 && k < 40) begin @(posedge clk); #1; k++; end
    check("align_timeout", 32'(k < 40), 32'd1);
  endtask

  task automatic press(input int n);
    @(negedge clk) page_btn = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk) page_btn = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic reset_release_check(input string tag);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check_slot({tag, "_rel"}, 4'hF, 7'h7F);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check_slot({tag, "_pre"}, 4'hF, 7'h7F);
    end
    @(posedge clk); #1;
    check_slot({tag, "_tick1"}, 4'hE, 7'h40);
    check({tag, "_page"}, 32'(page), 32'd0);
    check({tag, "_led"}, 32'(led_carry), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_slot("in_reset", 4'hF, 7'h7F);
    reset_release_check("rst1");

    // Ticks 2..4 still show the zero snapshot; tick 4 captures a=3, b=5, product=0F.
    tick_wait(); check_slot("t2", 4'hD, 7'h40);
    tick_wait();
    tick_wait(); check_slot("t4", 4'h7, 7'h40);
    tick_wait(); check_slot("p0_d0", 4'hE, 7'h0E);
    tick_wait(); check_slot("p0_d1", 4'hD, 7'h40);
    tick_wait(); check_slot("p0_d2", 4'hB, 7'h12);
    tick_wait(); check_slot("p0_d3", 4'h7, 7'h30);
    tick_wait(); check_slot("p0_d0b", 4'hE, 7'h0E);

    // Product changes mid-scan; the rest of this scan keeps 0F.
    product = 8'hA2;
    tick_wait(); check_slot("hold_d1", 4'hD, 7'h40);
    tick_wait(); check_slot("hold_d2", 4'hB, 7'h12);
    tick_wait(); check_slot("hold_d3", 4'h7, 7'h30);
    tick_wait(); check_slot("new_d0", 4'hE, 7'h24);
    tick_wait(); check_slot("new_d1", 4'hD, 7'h08);

    // Short pulses are rejected.
    press(3); check("pulse3_page", 32'(page), 32'd0);
    press(6); check("pulse6_page", 32'(page), 32'd0);

    // Held press: page updates 11 cycles after the edge.
    @(negedge clk) page_btn = 1'b1;
    repeat (10) @(posedge clk);
    #1; check("btn_lat_pre", 32'(page), 32'd0);
    @(posedge clk); #1; check("btn_lat_hit", 32'(page), 32'd1);
    @(posedge clk);
    @(negedge clk) page_btn = 1'b0;
    repeat (20) @(posedge clk);
    #1; check("release_page", 32'(page), 32'd1);

    press(12); check("press_p2", 32'(page), 32'd2);
    press(12); check("press_wrap", 32'(page), 32'd0);
    press(12); check("press_p1", 32'(page), 32'd1);

    // Page 1 contents.
    sum = 4'h7; carry_out = 1'b1; logical_shift = 4'h4; arithmetic_shift = 4'hD;
    align_digit3();
    check("led_carry1", 32'(led_carry), 32'd1);
    tick_wait(); check_slot("p1_d0", 4'hE, 7'h21);
    tick_wait(); check_slot("p1_d1", 4'hD, 7'h19);
    tick_wait(); check_slot("p1_d2", 4'hB, 7'h78);
    tick_wait(); check_slot("p1_d3", 4'h7, 7'h79);

    // Page 2 contents, then reset while digit 2 is lit.
    press(12); check("press_p2b", 32'(page), 32'd2);
    combined = 8'h5C;
    align_digit3();
    tick_wait(); check_slot("p2_d0", 4'hE, 7'h46);
    tick_wait(); check_slot("p2_d1", 4'hD, 7'h12);
    tick_wait(); check_slot("p2_d2", 4'hB, 7'h7F);
    #3 rst_n = 1'b0;
    #1;
    check_slot("async_rst", 4'hF, 7'h7F);
    check("async_rst_page", 32'(page), 32'd0);
    check("async_rst_led", 32'(led_carry), 32'd0);
    reset_release_check("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_result_display.md
# alu_result_display

Time-multiplexed 4-digit seven-segment driver downstream of the shift/arithmetic test unit. It samples that unit's result buses (operands, shifts, concatenation, sum/carry, product) into a coherent snapshot once per scan. It shows one of three pages of hex digits; a debounced push-button advances the page. Outputs drive common-anode board displays directly (active-low).

## Interface
- REFRESH_DIV, 50000: clk cycles per digit slot (≥2)
- DEBOUNCE_CYCLES, 500000: cycles button must be stable to register (≥2)

- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- a  input  4  operand A
- b  input  4  operand B
- logical_shift  input  4  A<<1 result
- arithmetic_shift  input  4  signed A>>>1 result
- combined  input  8  {A, logical_shift}
- sum  input  4  A+B low bits
- carry_out  input  1  A+B carry
- product  input  8  A*B
- page_btn  input  1  raw asynchronous push-button, active-high
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
- an_n  output  4  digit enables, an_n[0] rightmost, active-low
- page  output  2  current page (0..2)
- led_carry  output  1  snapshot carry_out

## Operation
- Reset values: seg_n=7'h7F, an_n=4'hF, page=0, led_carry=0, snapshot=all zero, digit index=0, prescaler=0, debounce stable level=0, debounce counter=0.
- Prescaler counts 0..REFRESH_DIV-1; the terminal count is the "tick".
- On each tick: an_n <= ~(1<<idx); seg_n <= decode(digit(page, idx)); idx <= idx+1 mod 4.
- Snapshot: on the tick where idx==3, all inputs register into the snapshot; the following scan (digits 0..3) uses it. Input changes at other times are invisible until then.
- Page map (digit3, digit2, digit1, digit0):
  - page 0: a, b, product[7:4], product[3:0]
  - page 1: {3'b0,carry_out}, sum, logical_shift, arithmetic_shift
  - page 2: blank, blank, combined[7:4], combined[3:0]
- Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, blank=1111111.
- Button path:
  - 2-flop synchronizer.
  - While synchronized level ≠ stable level, counter increments; any cycle they are equal clears the counter.
  - When counter reaches DEBOUNCE_CYCLES-1 with mismatch still present, stable level flips and counter clears.
- Page: rising edge of stable level advances page 0→1→2→0. Page 3 is unreachable; if ever present, treat as 0.
- led_carry = snapshot carry_out.

## Timing
- First tick occurs REFRESH_DIV cycles after rst_n deasserts. It drives an_n=1110 and shows digit 0 of the all-zero snapshot.
- seg_n and an_n change only on ticks, always in the same cycle; no cross-digit ghosting.
- Page change is visible from the next tick onward; the current slot is not altered mid-slot.
- Button latency: 2 sync cycles + DEBOUNCE_CYCLES cycles from a clean edge to page update; 1 more cycle to the page output register.
- Button edge coincident with a tick: both take effect; the tick uses the old page.
- rst_n low at any time immediately forces all reset values, including mid-scan and mid-debounce.

## Test plan
(REFRESH_DIV=4, DEBOUNCE_CYCLES=8)
- Reset release -> an_n=1111, seg_n=1111111 for 4 cycles, then an_n=1110, seg_n=1000000; page=0, led_carry=0.
- a=3, b=5, product=8'h0F held, page 0 -> after next idx==3 tick, scan shows digit0 F(0001110), digit1 0(1000000), digit2 5(0010010), digit3 3(0110000).
- Button pulses of 3 and 6 cycles -> page stays 0. Held 12 cycles -> page=1. Two further clean presses -> page 2, then 0.
- Page 1, sum=7, carry_out=1, logical_shift=4, arithmetic_shift=D -> digits 0..3 = d(0100001), 4(0011001), 7(1111000), 1(1111001); led_carry=1.
- Change product from 8'h0F to 8'hA2 while idx==1 -> remaining digits of the scan still show 0F; A2 appears after the next snapshot.
- rst_n pulled low while digit 2 is displayed on page 2 -> same-cycle an_n=1111, seg_n=1111111, page=0; restart matches the first scenario.
